// File: rtl/duty_ramp.sv
// Soft-start / fade generator: walks the PWM duty value toward an accepted target in
// programmable increments at a programmable step rate, with busy/done status.
module duty_ramp #(
    parameter int unsigned R         = 8,
    parameter int unsigned STEP_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [R:0]           target,
    input  logic                 target_valid,
    output logic                 target_ready,
    input  logic [STEP_BITS-1:0] step_period,
    input  logic [R-1:0]         step_size,
    output logic [R:0]           duty,
    output logic                 busy,
    output logic                 done
);

    localparam logic [R:0] FullScale = {1'b1, {R{1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StRampUp,
        StRampDown
    } state_e;

    state_e               state_q;
    logic [R:0]           duty_q;
    logic [R:0]           tgt_q;
    logic [STEP_BITS-1:0] presc_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;

    logic [R:0]   tgt_clamp;
    logic [R:0]   step_eff;
    logic [R+1:0] step_w;
    logic [R+1:0] duty_w;
    logic [R+1:0] tgt_w;
    logic [R+1:0] up_w;
    logic [R:0]   up_next;
    logic [R:0]   dn_next;
    logic [R:0]   step_next;
    logic         step_due;

    // Step arithmetic is done one bit wider than duty so neither the sum nor the
    // guard comparison can wrap; results are clamped at the stored target.
    always_comb begin
        tgt_clamp = (target > FullScale) ? FullScale : target;
        step_eff  = (step_size == '0) ? {{R{1'b0}}, 1'b1} : {1'b0, step_size};
        step_w    = {1'b0, step_eff};
        duty_w    = {1'b0, duty_q};
        tgt_w     = {1'b0, tgt_q};
        up_w      = duty_w + step_w;
        up_next   = (up_w > tgt_w) ? tgt_q : up_w[R:0];
        dn_next   = (duty_w < (tgt_w + step_w)) ? tgt_q : (duty_q - step_eff);
        step_next = (state_q == StRampUp) ? up_next : dn_next;
        step_due  = (presc_q == step_period);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            duty_q  <= '0;
            tgt_q   <= '0;
            presc_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (target_valid) begin
                        tgt_q   <= tgt_clamp;
                        presc_q <= '0;
                        if (tgt_clamp > duty_q) begin
                            state_q <= StRampUp;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end else if (tgt_clamp < duty_q) begin
                            state_q <= StRampDown;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRampUp, StRampDown: begin
                    if (step_due) begin
                        presc_q <= '0;
                        duty_q  <= step_next;
                        if (step_next == tgt_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        // A period lowered below the count wraps around before matching.
                        presc_q <= presc_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign duty         = duty_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign target_ready = ready_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: directed literal checks plus randomized traffic compared every
// cycle against an arithmetic model of the ramp behaviour.
module tb_duty_ramp;

    localparam int R    = 8;
    localparam int SB   = 16;
    localparam int FULL = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [R:0]    target = '0;
    logic          target_valid = 1'b0;
    logic          target_ready;
    logic [SB-1:0] step_period = '0;
    logic [R-1:0]  step_size = '0;
    logic [R:0]    duty;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: current duty, stored target, ramp in progress, done pulse,
    // cycles elapsed since the last step (or acceptance).
    int m_duty  = 0;
    int m_tgt   = 0;
    int m_since = 0;
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;

    duty_ramp #(
        .R         (R),
        .STEP_BITS (SB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .step_period  (step_period),
        .step_size    (step_size),
        .duty         (duty),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a step happens step_period+1 cycles after the previous
    // one, moving duty toward the target by max(step_size,1) without overshoot.
    always @(posedge clk) begin
        int s;
        if (reset) begin
            m_duty  = 0;
            m_tgt   = 0;
            m_since = 0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (target_valid) begin
                    m_tgt   = (int'(target) > FULL) ? FULL : int'(target);
                    m_since = 0;
                    if (m_tgt == m_duty) m_done = 1'b1;
                    else m_busy = 1'b1;
                end
            end else begin
                m_since++;
                if (m_since == int'(step_period) + 1) begin
                    m_since = 0;
                    s = (step_size == 0) ? 1 : int'(step_size);
                    if (m_tgt > m_duty) m_duty = (m_duty + s > m_tgt) ? m_tgt : m_duty + s;
                    else m_duty = (m_duty - s < m_tgt) ? m_tgt : m_duty - s;
                    if (m_duty == m_tgt) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        chk("duty", int'(duty), m_duty);
        chk("busy", int'(busy), int'(m_busy));
        chk("ready", int'(target_ready), int'(!m_busy));
        chk("done", int'(done), int'(m_done));
    end

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic accept(input int t, input int sz, input int per);
        target       = (R+1)'(t);
        step_size    = R'(sz);
        step_period  = SB'(per);
        target_valid = 1'b1;
        cyc();
        target_valid = 1'b0;
    endtask

    initial begin
        int dn_exp[3];
        int n;
        dn_exp = '{60, 20, 5};

        // Reset for two edges, then release.
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        chk("rst_duty", int'(duty), 0);
        chk("rst_ready", int'(target_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        // Ramp up 0 -> 100 by 10 every 4 cycles.
        accept(100, 10, 3);
        chk("up_e0_ready", int'(target_ready), 0);
        chk("up_e0_busy", int'(busy), 1);
        for (int k = 1; k <= 40; k++) begin
            cyc();
            chk("up_duty", int'(duty), 10 * (k / 4));
            chk("up_done", int'(done), (k == 40) ? 1 : 0);
            chk("up_ready", int'(target_ready), (k == 40) ? 1 : 0);
        end

        // Ramp down 100 -> 5 by 40 every cycle, final step clamps at target.
        accept(5, 40, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("dn_duty", int'(duty), dn_exp[k-1]);
            chk("dn_done", int'(done), (k == 3) ? 1 : 0);
        end

        // Back to 0, then a clamped full-scale request.
        accept(0, 255, 0);
        cyc();
        chk("zero_duty", int'(duty), 0);
        accept(300, 255, 0);
        chk("fs_busy", int'(busy), 1);
        cyc();
        chk("fs_duty1", int'(duty), 255);
        chk("fs_done1", int'(done), 0);
        cyc();
        chk("fs_duty2", int'(duty), 256);
        chk("fs_done2", int'(done), 1);

        // Request while busy is ignored; ramp 256 -> 100 takes 16 steps of 2 cycles.
        accept(100, 10, 1);
        for (int k = 1; k <= 4; k++) cyc();
        target       = 9'd50;
        target_valid = 1'b1;
        cyc();
        target_valid = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            cyc();
            n++;
        end
        chk("ign_done_seen", int'(done), 1);
        chk("ign_latency", 5 + n, 32);
        chk("ign_duty", int'(duty), 100);

        // Equal target accepted in the done cycle: done again, busy never rises.
        accept(100, 7, 2);
        chk("eq_done", int'(done), 1);
        chk("eq_busy", int'(busy), 0);
        chk("eq_duty", int'(duty), 100);
        cyc();
        chk("eq_done_after", int'(done), 0);
        chk("eq_busy_after", int'(busy), 0);

        // Reset mid-ramp, before the third step.
        accept(0, 255, 0);
        cyc();
        accept(100, 10, 3);
        for (int k = 1; k <= 9; k++) cyc();
        chk("mr_pre_duty", int'(duty), 20);
        reset = 1'b1;
        cyc();
        chk("mr_duty", int'(duty), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_ready", int'(target_ready), 1);
        chk("mr_done", int'(done), 0);
        cyc();
        reset = 1'b0;
        cyc();
        chk("mr_done_after", int'(done), 0);

        // Randomized traffic; the per-cycle compare checks against the model.
        for (int i = 0; i < 20000; i++) begin
            reset        = ($urandom_range(0, 499) == 0);
            target_valid = ($urandom_range(0, 3) == 0);
            target       = (R+1)'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) step_size = R'($urandom_range(0, 3));
            else step_size = R'($urandom_range(0, 255));
            if (!m_busy) step_period = SB'($urandom_range(0, 3));
            else if ($urandom_range(0, 49) == 0 && step_period < 8) step_period = step_period + 1'b1;
            cyc();
        end
        reset        = 1'b0;
        target_valid = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/duty_ramp.md
# duty_ramp

Soft-start / fade generator that sits directly upstream of the PWM stage and drives its `duty` input. It accepts a target duty value through a valid/ready handshake, then moves its `duty` output toward the target in programmable increments at a programmable step rate, so loads such as LEDs and motors never see a duty-cycle jump. It reports progress with `busy` and a one-cycle `done` pulse.

## Interface
- `R`, 8: PWM resolution. `duty` and `target` are R+1 bits wide; 2^R means 100 %.
- `STEP_BITS`, 16: width of the step-rate prescaler.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  reset, synchronous and active-high.
- `target`  input  R+1  requested final duty; values above 2^R are clamped to 2^R at acceptance.
- `target_valid`  input  1  the target is presented this cycle.
- `target_ready`  output  1  high only in IDLE; a transfer occurs on an edge where valid && ready.
- `step_period`  input  STEP_BITS  the step occurs every step_period+1 cycles; sampled continuously.
- `step_size`  input  R  increment per step; 0 is treated as 1; sampled at each step.
- `duty`  output  R+1  registered duty value, connected to the PWM `duty` input.
- `busy`  output  1  high while in RAMP_UP or RAMP_DOWN.
- `done`  output  1  one-cycle pulse when `duty` reaches the target.

## Operation
- State machine with states IDLE, RAMP_UP and RAMP_DOWN.
- Reset values: state IDLE, `duty`=0, `target_ready`=1, `busy`=0, `done`=0, prescaler=0, stored target=0.
- **IDLE, on handshake:**
  - Store clamp(target) and clear the prescaler.
  - If clamp(target) > duty: go to RAMP_UP, busy=1, ready=0.
  - If clamp(target) < duty: go to RAMP_DOWN, busy=1, ready=0.
  - If equal: stay in IDLE, pulse `done` on the same edge, and leave `duty` unchanged.
- **Prescaler in RAMP states:**
  - Increments by 1 each cycle.
  - When it equals `step_period`, that edge applies one step and clears the prescaler.
  - If `step_period` is changed mid-ramp to a value below the current count, the prescaler counts up through wrap-around (modulo 2^STEP_BITS) until it matches.
- **Step arithmetic:**
  - Computed in R+2 bits; no overflow or underflow reaches `duty`.
  - RAMP_UP: duty ← min(duty + s, tgt).
  - RAMP_DOWN: duty ← (duty < tgt + s) ? tgt : duty − s.
  - s = max(step_size, 1).
- **Completion:** on the edge where the step makes duty == tgt: state ← IDLE, busy ← 0, ready ← 1, and done ← 1 for exactly one cycle.
- **No retargeting:** `target_valid` while busy is ignored. The request is not queued, and the producer must hold it until ready.
- **Reset mid-ramp:** all registers return to their reset values on that edge. `duty` is 0 in the next cycle and no `done` pulse is issued.
- **Back-to-back transfers:** a new transfer is allowed in the same cycle that `done` is high, because ready is already 1.

## Timing
- Every output is a register; there is no combinational path from inputs to outputs.
- Handshake accepted at edge E0. The first `duty` change appears at edge E0 + (step_period+1).
- Each following step occurs step_period+1 cycles after the previous one.
- Total ramp time is ceil(|tgt − duty0| / s) × (step_period+1) cycles.
- `done` is high in the same cycle that the final `duty` value first appears.
- `target_ready` rises in that same cycle.
- Equal-target case: `done` is high in the cycle after E0, and `busy` never asserts.
- With step_period=0, `duty` changes on every cycle.

## Test plan
- **Reset:** assert reset for 2 cycles, then release -> duty=0, target_ready=1, busy=0, done=0.
- **Ramp up, R=8:** target=100, step_size=10, step_period=3, starting from duty=0 -> duty reads 10, 20, …, 100, first appearing 4, 8, …, 40 cycles after acceptance. `done` is a single pulse at cycle 40, and ready=0 during cycles 1–39.
- **Ramp down with clamp at target:** starting from duty=100, target=5, step_size=40, step_period=0 -> duty reads 60, 20, 5 on consecutive cycles, with `done` high together with 5.
- **Full-scale clamp:** target=300, step_size=255, step_period=0, starting from 0 -> the stored target is 256 and duty reads 255, then 256 with `done`. Duty never exceeds 256.
- **Busy ignore and equal target:** pulse target_valid with 50 mid-ramp -> ignored, and the ramp completes to the original target. Then present target == current duty -> `done` the next cycle, busy stays 0, duty unchanged.
- **Reset mid-ramp:** assert reset during the 3rd step of the ramp-up case -> duty=0, busy=0, ready=1 the next cycle, with no `done` pulse.
